jk_exerciser: RTL and testbench

JK_EXERCISER -- requirements
Module: jk_exerciser

---
 rtl/jk_pkg.sv | 37 +++
 rtl/jk_lfsr8.sv | 25 ++
 rtl/jk_exerciser.sv | 117 +++++++++++
 tb/tb_jk_exerciser.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared types and helpers for the JK flop exerciser.
package jk_pkg;

  localparam int unsigned LFSR_W = 8;

  // Feedback taps for x^8+x^6+x^5+x^4+1, shift-left Fibonacci form (bits 7,5,4,3)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Next state of a synchronous JK flop: reset beats set beats JK
  function automatic logic jk_next(input logic q, input logic j, input logic k,
                                   input logic set, input logic rst);
    logic nq;
    nq = q;
    if (rst) begin
      nq = 1'b0;
    end else if (set) begin
      nq = 1'b1;
    end else begin
      case ({j, k})
        2'b00:   nq = q;
        2'b01:   nq = 1'b0;
        2'b10:   nq = 1'b1;
        default: nq = ~q;
      endcase
    end
    return nq;
  endfunction

endpackage

// File: rtl/jk_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous load and advance enable.
module jk_lfsr8
  import jk_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              en,
  output logic [LFSR_W-1:0] value
);

  // Load has priority over advance; reset returns to the seed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= SEED;
    end else if (load) begin
      value <= SEED;
    end else if (en) begin
      value <= {value[LFSR_W-2:0], ^(value & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/jk_exerciser.sv
// Drives pseudo-random J/K/set/reset vectors into an external JK flop and
// counts cycles where its output disagrees with an internal reference model.
module jk_exerciser
  import jk_pkg::*;
#(
  parameter int unsigned N_VECTORS = 64,
  parameter logic [7:0]  LFSR_SEED = 8'hA5,
  parameter int unsigned ERR_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             q,
  output logic             j,
  output logic             k,
  output logic             ff_set,
  output logic             ff_reset,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      vec_count
);

  localparam int unsigned      VEC_W   = 16;
  localparam logic [VEC_W-1:0] N_VEC   = VEC_W'(N_VECTORS);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_t             state;
  state_t             state_d;
  logic               start_q;
  logic               exp_q;
  logic [LFSR_W-1:0]  lfsr;
  logic               lfsr_load;
  logic               lfsr_en;
  logic               cmp_en;
  logic [ERR_W-1:0]   err_d;
  logic               unused_lfsr_bits;

  // Bits 3:2 of the LFSR do not steer any drive signal
  assign unused_lfsr_bits = ^lfsr[3:2];

  jk_lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .en    (lfsr_en),
    .value (lfsr)
  );

  // Next-state, LFSR control and saturating error update
  always_comb begin
    state_d   = state;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    cmp_en    = 1'b0;
    err_d     = err_count;

    case (state)
      IDLE:    if (start) state_d = INIT;
      INIT:    state_d = RUN;
      RUN:     if (vec_count == N_VEC) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (start && !start_q) state_d = INIT;
      default: state_d = IDLE;
    endcase

    lfsr_load = (state_d == INIT);
    lfsr_en   = (state_d == RUN);
    // q reflects the previous cycle's drive during RUN and DRAIN
    cmp_en    = (state == RUN) || (state == DRAIN);

    if (state_d == INIT) begin
      err_d = '0;
    end else if (cmp_en && (q != exp_q) && (err_count != ERR_MAX)) begin
      err_d = err_count + ERR_W'(1);
    end
  end

  // State, registered drive/status outputs and the reference flop model
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      j         <= 1'b0;
      k         <= 1'b0;
      ff_set    <= 1'b0;
      ff_reset  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      vec_count <= '0;
      exp_q     <= 1'b0;
    end else begin
      state     <= state_d;
      start_q   <= start;
      j         <= (state_d == RUN) && lfsr[0];
      k         <= (state_d == RUN) && lfsr[1];
      ff_set    <= (state_d == RUN) && (lfsr[7:4] == 4'hF);
      ff_reset  <= (state_d == INIT);
      busy      <= (state_d == INIT) || (state_d == RUN) || (state_d == DRAIN);
      done      <= (state_d == DONE);
      pass      <= (state_d == DONE) && (err_d == '0);
      err_count <= err_d;
      if (state_d == INIT) begin
        vec_count <= '0;
      end else if (state_d == RUN) begin
        vec_count <= vec_count + VEC_W'(1);
      end
      exp_q     <= (state_d == INIT) ? 1'b0 : jk_next(exp_q, j, k, ff_set, ff_reset);
    end
  end

endmodule

// File: tb/tb_jk_exerciser.sv
// Bench for jk_exerciser: run-level reference model plus directed scenarios.
module tb_jk_exerciser;
  import jk_pkg::*;

  localparam int         NA   = 64;
  localparam logic [7:0] SEED = 8'hA5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- instance A: N=64, ERR_W=8, q selectable ----------------
  logic reset_a = 1'b0, start_a = 1'b0, q_a;
  logic j_a, k_a, set_a, ffr_a, busy_a, done_a, pass_a;
  logic [7:0]  err_a;
  logic [15:0] vec_a;
  bit flop_a;
  bit q_mode = 1'b0;  // 1: q tied low

  always @(posedge clk) flop_a <= jk_next(flop_a, j_a, k_a, set_a, ffr_a);
  assign q_a = q_mode ? 1'b0 : flop_a;

  jk_exerciser #(.N_VECTORS(NA), .LFSR_SEED(SEED), .ERR_W(8)) dut_a (
    .clk(clk), .reset(reset_a), .start(start_a), .q(q_a),
    .j(j_a), .k(k_a), .ff_set(set_a), .ff_reset(ffr_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .vec_count(vec_a)
  );

  // ---------------- instance B: N=1, correct flop ----------------
  logic reset_bc = 1'b0, start_b = 1'b0, q_b;
  logic j_b, k_b, set_b, ffr_b, busy_b, done_b, pass_b;
  logic [7:0]  err_b;
  logic [15:0] vec_b;
  bit flop_b;
  always @(posedge clk) flop_b <= jk_next(flop_b, j_b, k_b, set_b, ffr_b);
  assign q_b = flop_b;

  jk_exerciser #(.N_VECTORS(1), .LFSR_SEED(SEED), .ERR_W(8)) dut_b (
    .clk(clk), .reset(reset_bc), .start(start_b), .q(q_b),
    .j(j_b), .k(k_b), .ff_set(set_b), .ff_reset(ffr_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .vec_count(vec_b)
  );

  // ---------------- instance C: N=64, ERR_W=2, q inverted ----------------
  logic start_c = 1'b0, q_c;
  logic j_c, k_c, set_c, ffr_c, busy_c, done_c, pass_c;
  logic [1:0]  err_c;
  logic [15:0] vec_c;
  bit flop_c;
  always @(posedge clk) flop_c <= jk_next(flop_c, j_c, k_c, set_c, ffr_c);
  assign q_c = ~flop_c;

  jk_exerciser #(.N_VECTORS(NA), .LFSR_SEED(SEED), .ERR_W(2)) dut_c (
    .clk(clk), .reset(reset_bc), .start(start_c), .q(q_c),
    .j(j_c), .k(k_c), .ff_set(set_c), .ff_reset(ffr_c),
    .busy(busy_c), .done(done_c), .pass(pass_c),
    .err_count(err_c), .vec_count(vec_c)
  );

  // ---------------- reference model for instance A ----------------
  logic [7:0] seq [NA];        // vector i drives RUN cycle i
  bit         exp_after [NA+1]; // flop value after i vectors
  int         cum_q0 [NA+2];    // mismatches of a stuck-at-0 q over the first t checks

  int m_cyc      = 0;  // 0 idle, 1 init, 2..NA+1 run, NA+2 drain, NA+3 done
  bit m_rst_pend = 1'b0;
  bit m_start_pv = 1'b0;
  bit m_mode     = 1'b0;
  bit chk_en     = 1'b0;

  // Phase tracking from start acceptance
  always @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      m_cyc      <= 0;
      m_rst_pend <= 1'b1;
      m_start_pv <= 1'b0;
      m_mode     <= 1'b0;
    end else begin
      m_rst_pend <= 1'b0;
      m_start_pv <= start_a;
      if ((m_cyc == 0 && start_a) || (m_cyc == NA + 3 && start_a && !m_start_pv)) begin
        m_cyc  <= 1;
        m_mode <= q_mode;
      end else if (m_cyc != 0 && m_cyc < NA + 3) begin
        m_cyc <= m_cyc + 1;
      end
    end
  end

  // Cycle-by-cycle comparison of instance A against the model
  bit run_ph;
  int vi, nchk, e_err, e_vec;
  always @(negedge clk) begin
    if (chk_en) begin
      run_ph = (m_cyc >= 2) && (m_cyc <= NA + 1);
      vi     = run_ph ? m_cyc - 2 : 0;
      nchk   = (m_cyc < 2) ? 0 : m_cyc - 2;
      e_err  = m_mode ? cum_q0[nchk] : 0;
      if (e_err > 255) e_err = 255;
      e_vec  = run_ph ? vi + 1 : ((m_cyc >= NA + 2) ? NA : 0);
      check("a_j",        32'(j_a),    32'(run_ph && seq[vi][0]));
      check("a_k",        32'(k_a),    32'(run_ph && seq[vi][1]));
      check("a_ff_set",   32'(set_a),  32'(run_ph && (seq[vi][7:4] == 4'hF)));
      check("a_ff_reset", 32'(ffr_a),  32'(m_cyc == 1 || m_rst_pend));
      check("a_busy",     32'(busy_a), 32'(m_cyc >= 1 && m_cyc <= NA + 2));
      check("a_done",     32'(done_a), 32'(m_cyc == NA + 3));
      check("a_pass",     32'(pass_a), 32'(m_cyc == NA + 3 && e_err == 0));
      check("a_err",      32'(err_a),  32'(e_err));
      check("a_vec",      32'(vec_a),  32'(e_vec));
    end
  end

  // One run of instance A from the current negedge; returns cycles to done
  task automatic run_a(input int extra_at, input int reset_at, output int cyc);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 1;
    while (!done_a && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start_a = (cyc == extra_at);
      if (cyc == 2) check("a_pin_jk_v0", 32'({j_a, k_a}), 32'(2'b10));
      if (cyc == 3) check("a_pin_jk_v1", 32'({j_a, k_a}), 32'(2'b01));
      if (cyc == 4) check("a_pin_jk_v2", 32'({j_a, k_a}), 32'(2'b10));
      if (cyc == reset_at) begin
        #2 reset_a = 1'b1;
        #1;
        check("a_abort_j",   32'(j_a),    32'(0));
        check("a_abort_k",   32'(k_a),    32'(0));
        check("a_abort_set", 32'(set_a),  32'(0));
        check("a_abort_ffr", 32'(ffr_a),  32'(1));
        check("a_abort_bdp", 32'({busy_a, done_a, pass_a}), 32'(0));
        check("a_abort_err", 32'(err_a),  32'(0));
        check("a_abort_vec", 32'(vec_a),  32'(0));
        return;
      end
    end
  endtask

  int cyc;
  logic [1:0] rec1, rec2;

  initial begin
    // Build the model tables
    seq[0] = SEED;
    for (int i = 1; i < NA; i++)
      seq[i] = {seq[i-1][6:0], seq[i-1][7] ^ seq[i-1][5] ^ seq[i-1][4] ^ seq[i-1][3]};
    exp_after[0] = 1'b0;
    for (int i = 0; i < NA; i++)
      exp_after[i+1] = jk_next(exp_after[i], seq[i][0], seq[i][1], seq[i][7:4] == 4'hF, 1'b0);
    cum_q0[0] = 0;
    for (int t = 0; t <= NA; t++) cum_q0[t+1] = cum_q0[t] + int'(exp_after[t]);
    check("model_seq1", 32'(seq[1]), 32'h4A);
    check("model_seq2", 32'(seq[2]), 32'h95);

    // Reset all instances
    #1 reset_a = 1'b1; reset_bc = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("a_rst_ffr",  32'(ffr_a),  32'(1));
    check("a_rst_busy", 32'(busy_a), 32'(0));
    check("b_rst_vec",  32'(vec_b),  32'(0));
    check("c_rst_err",  32'(err_c),  32'(0));
    repeat (2) @(negedge clk);
    #2 reset_a = 1'b0; reset_bc = 1'b0;
    @(negedge clk);
    check("a_idle_ffr_drop", 32'(ffr_a), 32'(0));

    // Clean run with a stray start mid-RUN
    q_mode = 1'b0;
    run_a(11, 0, cyc);
    check("a_run1_latency", 32'(cyc),    32'(67));
    check("a_run1_pass",    32'(pass_a), 32'(1));
    check("a_run1_err",     32'(err_a),  32'(0));
    check("a_run1_vec",     32'(vec_a),  32'(64));

    // q stuck low: restart from DONE
    @(negedge clk);
    q_mode = 1'b1;
    run_a(0, 0, cyc);
    check("a_q0_latency", 32'(cyc),              32'(67));
    check("a_q0_err",     32'(err_a),            32'(cum_q0[NA+1]));
    check("a_q0_nonzero", 32'(err_a != 8'd0),    32'(1));
    check("a_q0_pass",    32'(pass_a),           32'(0));
    repeat (2) @(negedge clk);
    check("a_q0_hold",    32'(err_a),            32'(cum_q0[NA+1]));

    // Abort in RUN cycle 20, then a full clean run
    q_mode = 1'b0;
    run_a(0, 21, cyc);
    repeat (2) @(negedge clk);
    #2 reset_a = 1'b0;
    @(negedge clk);
    run_a(0, 0, cyc);
    check("a_run3_latency", 32'(cyc),    32'(67));
    check("a_run3_pass",    32'(pass_a), 32'(1));
    check("a_run3_vec",     32'(vec_a),  32'(64));

    // Instance B: single vector
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("b_init_busy", 32'({busy_b, ffr_b}), 32'(2'b11));
    @(negedge clk);
    rec1 = {j_b, k_b};
    check("b_run_jk",   32'(rec1),  32'(2'b10));
    check("b_run_vec",  32'(vec_b), 32'(1));
    check("b_run_busy", 32'(busy_b), 32'(1));
    @(negedge clk);
    check("b_drain", 32'({busy_b, done_b, j_b}), 32'(3'b100));
    @(negedge clk);
    check("b_done",  32'({busy_b, done_b, pass_b}), 32'(3'b011));
    check("b_vec",   32'(vec_b), 32'(1));

    // Second run with start held high through DONE
    start_b = 1'b1;
    @(negedge clk);
    check("b2_init", 32'({busy_b, ffr_b}), 32'(2'b11));
    @(negedge clk);
    rec2 = {j_b, k_b};
    check("b2_same_jk", 32'(rec2), 32'(rec1));
    @(negedge clk);
    check("b2_drain", 32'(busy_b), 32'(1));
    @(negedge clk);
    check("b2_done", 32'({busy_b, done_b, pass_b}), 32'(3'b011));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("b2_held_start", 32'({busy_b, done_b}), 32'(2'b01));
    end
    start_b = 1'b0;

    // Instance C: saturation with ERR_W=2
    @(negedge clk);
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    cyc = 1;
    while (!done_c && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 40) check("c_mid_sat", 32'(err_c), 32'(3));
    end
    check("c_latency", 32'(cyc),    32'(67));
    check("c_err_sat", 32'(err_c),  32'(3));
    check("c_pass",    32'(pass_c), 32'(0));
    check("c_vec",     32'(vec_c),  32'(64));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
